// File: rtl/isi_spike_gen.sv
// ISI spike generator: queues inter-spike intervals and replays them as one-cycle spikes,
// counting each interval down in ce ticks.
module isi_spike_gen #(
  parameter int unsigned bit_isi = 8,
  parameter int unsigned fifo_aw = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ce,
  input  logic               en,
  input  logic [bit_isi-1:0] isi_data,
  input  logic               isi_valid,
  output logic               isi_ready,
  output logic               spike,
  output logic [bit_isi-1:0] q,
  output logic               busy,
  output logic               ur,
  output logic [fifo_aw:0]   level
);

  localparam int unsigned Depth = 2 ** fifo_aw;
  localparam logic [fifo_aw:0] LevelFull = Depth[fifo_aw:0];
  localparam logic [bit_isi-1:0] QOne = {{(bit_isi-1){1'b0}}, 1'b1};

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StCount = 1'b1;

  logic [bit_isi-1:0] mem_q [Depth];
  logic [fifo_aw-1:0] wr_ptr_q, wr_ptr_d;
  logic [fifo_aw-1:0] rd_ptr_q, rd_ptr_d;
  logic [fifo_aw:0]   level_q, level_d;
  logic [0:0]         state_q, state_d;
  logic [bit_isi-1:0] q_q, q_d;
  logic               spike_q, spike_d;
  logic               ur_q, ur_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               fire;
  logic [bit_isi-1:0] head;

  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = isi_valid && !full;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    ur_d     = ur_q;
    pop      = 1'b0;
    fire     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    unique case (state_q)
      StIdle: begin
        if (en && !empty) begin
          pop     = 1'b1;
          q_d     = head;
          state_d = StCount;
        end
      end
      StCount: begin
        if (en && ce) begin
          if (q_q != QOne) begin
            // N=0 wraps to all-ones here, giving 2**bit_isi ticks
            q_d = q_q - 1'b1;
          end else begin
            fire = 1'b1;
            if (!empty) begin
              pop = 1'b1;
              q_d = head;
            end else begin
              q_d     = '0;
              state_d = StIdle;
              ur_d    = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    spike_d = fire;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      q_q      <= '0;
      spike_q  <= 1'b0;
      ur_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      spike_q  <= spike_d;
      ur_q     <= ur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (!clr && push) mem_q[wr_ptr_q] <= isi_data;
  end

  assign isi_ready = !full;
  assign spike     = spike_q;
  assign q         = q_q;
  assign busy      = (state_q == StCount);
  assign ur        = ur_q;
  assign level     = level_q;

endmodule

// File: doc/isi_spike_gen.md
Name: isi_spike_gen

Overview:
- Converts a stream of inter-spike interval (ISI) values back into a spike train. It is the transmit-side counterpart of the ISI counter.
- Interval values are queued through a valid/ready interface. Each value is counted down in `ce` ticks, and a one-cycle spike pulse is emitted when the interval expires.
- Sits in the LandscapeSampling path wherever a sampled ISI sequence must be replayed as events.

Parameters:
- bit_isi, 8: width of ISI values and of the internal down-counter.
- fifo_aw, 1: interval queue address width; depth = 2**fifo_aw entries.

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- ce  in  1  time-base tick; one tick = one ISI unit
- en  in  1  run enable; 0 pauses counting and popping
- isi_data  in  bit_isi  interval value N
- isi_valid  in  1  isi_data valid
- isi_ready  out  1  queue can accept a value
- spike  out  1  one-cycle spike pulse
- q  out  bit_isi  remaining ticks in the current interval
- busy  out  1  an interval is being counted
- ur  out  1  sticky underrun flag
- level  out  fifo_aw+1  number of queued intervals

Behaviour:
- **Reset.** `clr` is sampled on `posedge clk`. It flushes the queue, sets state to IDLE, and drives `spike=0`, `q=0`, `busy=0`, `ur=0`, `level=0`.
- **Queue.** Registered FIFO. `isi_ready = !full`, taken from registered state.
  - A push occurs when `isi_valid && isi_ready`.
  - A push while full is not accepted; the producer must hold the value.
  - Push and pop in the same cycle are both performed; `level` is unchanged.
- **Interval semantics.** Value N produces a spike on the N-th `ce` tick after load. N=0 means 2**bit_isi ticks; the counter wraps from 0 to all-ones.
- **State IDLE.** If `en` and queue not empty: pop the head, set `q<=head`, go to COUNT. Load latency is 1 cycle after the value is visible at the queue head.
- **State COUNT** (`busy=1`):
  - If `en && ce && q!=1`: `q<=q-1`.
  - If `en && ce && q==1`: fire.
  - If `en` is 0, `ce` is ignored and `q` holds (pause, no loss of state).
- **Fire.** `spike<=1` for exactly one cycle, i.e. the cycle after the final `ce`. In the same edge:
  - If queue not empty: pop and reload `q`, stay in COUNT (back-to-back, no lost ticks).
  - Else: `q<=0`, go to IDLE, and set `ur<=1` while `en` is high.
- **Underrun flag.** `ur` clears only on `clr`.
- **Disable.** `en` falling in IDLE: no pop. Values may still be pushed while `en=0`.
- **Spike spacing.** Consecutive spikes are separated by exactly N `ce` ticks when the queue never runs dry. With `ce` held high, the spacing is N clk cycles.
- **`clr` mid-operation.** Aborts the current interval immediately. A fire pending in that cycle does not produce a spike.
- **Width rules.**
  - `q` arithmetic is modulo 2**bit_isi.
  - `level` counts 0..2**fifo_aw without wrap.
- **Outputs.** All outputs are registered except `isi_ready`, which is decoded from registered full.
- **Implementation.** Two-process style: a next-state block plus a register block.

Test Plan:
1. bit_isi=8, `ce=1`, `en=1`; push N=3 at cycle 0 → `q` loads 3 at cycle 2, counts 2,1; `spike` high only in cycle 5; `ur=1` from cycle 5.
2. Push 2, then 2 on consecutive cycles with `ce=1` → `spike` in cycles 4 and 6 (spacing 2 cycles); `busy` stays high between; then `ur` sets.
3. Push N=0, `ce=1` → exactly 256 `ce` ticks from load to the fire tick; `q` reads 255 after the first tick.
4. `ce` high every 4th cycle, N=2 → `spike` appears the cycle after the second `ce` pulse post-load; no spike on intermediate cycles.
5. fifo_aw=1, `en=0`; push 5,6,7 → `level` reaches 2 and `isi_ready=0`, so 7 is not accepted. Raise `en`; drop `en` mid-count for 10 cycles → `q` frozen. Spikes then occur at 5 and 6 ticks; 7 is accepted once `isi_ready` returns.
6. Assert `clr` for one cycle while `q==1` and `ce=1` → no `spike`; next cycle `q=0`, `busy=0`, `ur=0`, `level=0`, `isi_ready=1`.
